// File: rtl/computer_if.sv
// Instruction-fetch bus between the core and the instruction ROM.
// The master side also owns an optional program-load port.
interface computer_if;
  logic [3:0]  addr;
  logic [14:0] data;
  logic        we;
  logic [3:0]  waddr;
  logic [14:0] wdata;

  modport master (
    output addr,
    output we,
    output waddr,
    output wdata,
    input  data
  );

  modport slave (
    input  addr,
    input  we,
    input  waddr,
    input  wdata,
    output data
  );
endinterface

// File: rtl/computer_top.sv
// Single-cycle 8-bit accumulator computer: PC, 16x15 ROM,
// A/B registers, operand muxes and an 8-bit ALU.
module pc_reg (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] o_pc
);
  logic [3:0] pc;

  always_ff @(posedge clk) begin
    if (rst) pc <= 4'd0;
    else     pc <= pc + 4'd1;
  end

  assign o_pc = pc;
endmodule

module inst_rom (
  input logic    clk,
  computer_if.slave bus
);
  logic [14:0] mem [0:15];

  // Programs are normally preloaded; the write port is tied off at the top.
  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.waddr] <= bus.wdata;
  end

  assign bus.data = mem[bus.addr];
endmodule

module reg8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ld,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= 8'h00;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module alu8 (
  input  logic [2:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_y
);
  logic [7:0] w_y;

  always_comb begin
    w_y = 8'h00;
    unique case (i_op)
      3'b000: w_y = i_a + i_b;
      3'b001: w_y = i_a - i_b;
      3'b010: w_y = i_a & i_b;
      3'b011: w_y = i_a | i_b;
      3'b100: w_y = i_a ^ i_b;
      3'b101: w_y = ~i_a;
      3'b110: w_y = {i_a[6:0], 1'b0};
      3'b111: w_y = {1'b0, i_a[7:1]};
      default: w_y = 8'h00;
    endcase
  end

  assign o_y = w_y;
endmodule

module computer_top (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] alu_result_out_bus
);
  logic [3:0]  pc_out_bus;
  logic [14:0] im_out_bus;
  logic [7:0]  regA_out_bus;
  logic [7:0]  regB_out_bus;

  logic        w_la;
  logic        w_lb;
  logic        w_sa;
  logic        w_sb;
  logic [2:0]  w_op;
  logic [7:0]  w_k;
  logic [7:0]  w_opa;
  logic [7:0]  w_opb;

  computer_if fetch_if ();

  assign fetch_if.addr  = pc_out_bus;
  assign fetch_if.we    = 1'b0;
  assign fetch_if.waddr = 4'd0;
  assign fetch_if.wdata = 15'd0;
  assign im_out_bus     = fetch_if.data;

  pc_reg PC (
    .clk  (clk),
    .rst  (rst),
    .o_pc (pc_out_bus)
  );

  inst_rom IM (
    .clk (clk),
    .bus (fetch_if.slave)
  );

  assign w_la = im_out_bus[14];
  assign w_lb = im_out_bus[13];
  assign w_sa = im_out_bus[12];
  assign w_sb = im_out_bus[11];
  assign w_op = im_out_bus[10:8];
  assign w_k  = im_out_bus[7:0];

  assign w_opa = w_sa ? 8'h00 : regA_out_bus;
  assign w_opb = w_sb ? w_k   : regB_out_bus;

  alu8 ALU (
    .i_op (w_op),
    .i_a  (w_opa),
    .i_b  (w_opb),
    .o_y  (alu_result_out_bus)
  );

  reg8 regA (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_la),
    .i_d  (alu_result_out_bus),
    .o_q  (regA_out_bus)
  );

  reg8 regB (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_lb),
    .i_d  (alu_result_out_bus),
    .o_q  (regB_out_bus)
  );
endmodule

// File: tb/tb_computer_top.sv
// Directed-vector bench for computer_top.
// Programs are written straight into the ROM array.
module tb_computer_top;
  logic       clk;
  logic       rst;
  logic [7:0] alu;

  int n_cmp;
  int n_bad;

  computer_top dut (
    .clk                (clk),
    .rst                (rst),
    .alu_result_out_bus (alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 16; i++) dut.IM.mem[i] = 15'h0000;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_rom();
    dut.IM.mem[0] = 15'h5805;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (dut.pc_out_bus !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_pc got %0d want 0", dut.pc_out_bus);
    end
    n_cmp++;
    if (dut.regA_out_bus !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_A got %h want 00", dut.regA_out_bus);
    end
    n_cmp++;
    if (dut.regB_out_bus !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_B got %h want 00", dut.regB_out_bus);
    end
    n_cmp++;
    if (alu !== 8'h05) begin
      n_bad++;
      $display("FAIL reset_alu got %h want 05", alu);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_add;
    logic [7:0] exp_a [4];
    clear_rom();
    dut.IM.mem[0] = 15'h5805;
    dut.IM.mem[1] = 15'h3803;
    dut.IM.mem[2] = 15'h4000;
    dut.IM.mem[3] = 15'h4100;
    exp_a = '{8'h05, 8'h05, 8'h08, 8'h05};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        n_cmp++;
        if (alu !== 8'h08) begin
          n_bad++;
          $display("FAIL add_alu got %h want 08", alu);
        end
      end
      tick();
      n_cmp++;
      if (dut.regA_out_bus !== exp_a[i]) begin
        n_bad++;
        $display("FAIL load_add_A%0d got %h want %h",
                 i, dut.regA_out_bus, exp_a[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (dut.regB_out_bus !== 8'h03) begin
          n_bad++;
          $display("FAIL load_B got %h want 03", dut.regB_out_bus);
        end
      end
    end
    n_cmp++;
    if (dut.pc_out_bus !== 4'd4) begin
      n_bad++;
      $display("FAIL load_add_pc got %0d want 4", dut.pc_out_bus);
    end
  endtask

  task automatic test_logic;
    logic [14:0] ops  [6];
    logic [7:0]  seed [6];
    logic [7:0]  exp  [6];
    ops  = '{15'h4200, 15'h4300, 15'h4400,
             15'h4500, 15'h4600, 15'h4700};
    seed = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h81, 8'h81};
    exp  = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'h02, 8'h40};
    clear_rom();
    dut.IM.mem[0] = {7'b1011000, seed[0]};
    dut.IM.mem[1] = 15'h380F;
    for (int k = 0; k < 6; k++) begin
      dut.IM.mem[2 + 2 * k] = ops[k];
      if (k < 5) dut.IM.mem[3 + 2 * k] = {7'b1011000, seed[k + 1]};
    end
    do_reset();
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (alu !== exp[k]) begin
        n_bad++;
        $display("FAIL logic_alu%0d got %h want %h", k, alu, exp[k]);
      end
      tick();
      n_cmp++;
      if (dut.regA_out_bus !== exp[k]) begin
        n_bad++;
        $display("FAIL logic_A%0d got %h want %h",
                 k, dut.regA_out_bus, exp[k]);
      end
      if (k < 5) tick();
    end
  endtask

  task automatic test_wrap_dual;
    clear_rom();
    dut.IM.mem[0] = 15'h3801;
    dut.IM.mem[1] = 15'h4100;
    dut.IM.mem[2] = 15'h7807;
    do_reset();
    tick();
    n_cmp++;
    if (alu !== 8'hFF) begin
      n_bad++;
      $display("FAIL sub_wrap_alu got %h want ff", alu);
    end
    tick();
    n_cmp++;
    if (dut.regA_out_bus !== 8'hFF) begin
      n_bad++;
      $display("FAIL sub_wrap_A got %h want ff", dut.regA_out_bus);
    end
    tick();
    n_cmp++;
    if (dut.regA_out_bus !== 8'h07 || dut.regB_out_bus !== 8'h07) begin
      n_bad++;
      $display("FAIL dual_load got A=%h B=%h want 07/07",
               dut.regA_out_bus, dut.regB_out_bus);
    end
  endtask

  task automatic test_pc_wrap;
    clear_rom();
    dut.IM.mem[0] = 15'h5833;
    dut.IM.mem[1] = 15'h3844;
    for (int i = 2; i < 16; i++)
      dut.IM.mem[i] = {2'b00, 13'(i * 391)};
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    n_cmp++;
    if (dut.pc_out_bus !== 4'd15) begin
      n_bad++;
      $display("FAIL pc_15 got %0d want 15", dut.pc_out_bus);
    end
    tick();
    n_cmp++;
    if (dut.pc_out_bus !== 4'd0) begin
      n_bad++;
      $display("FAIL pc_wrap got %0d want 0", dut.pc_out_bus);
    end
    n_cmp++;
    if (dut.regA_out_bus !== 8'h33 || dut.regB_out_bus !== 8'h44) begin
      n_bad++;
      $display("FAIL nop_hold got A=%h B=%h want 33/44",
               dut.regA_out_bus, dut.regB_out_bus);
    end
  endtask

  task automatic test_reset_mid;
    clear_rom();
    dut.IM.mem[0] = 15'h5808;
    dut.IM.mem[1] = 15'h3803;
    dut.IM.mem[2] = 15'h4000;
    do_reset();
    tick();
    tick();
    n_cmp++;
    if (dut.pc_out_bus !== 4'd2 || dut.regA_out_bus !== 8'h08) begin
      n_bad++;
      $display("FAIL mid_setup got pc=%0d A=%h want 2/08",
               dut.pc_out_bus, dut.regA_out_bus);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (dut.pc_out_bus !== 4'd0 || dut.regA_out_bus !== 8'h00 ||
        dut.regB_out_bus !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset got pc=%0d A=%h B=%h want 0/00/00",
               dut.pc_out_bus, dut.regA_out_bus, dut.regB_out_bus);
    end
    n_cmp++;
    if (alu !== 8'h08) begin
      n_bad++;
      $display("FAIL restart_alu got %h want 08", alu);
    end
    tick();
    n_cmp++;
    if (dut.regA_out_bus !== 8'h08 || dut.pc_out_bus !== 4'd1) begin
      n_bad++;
      $display("FAIL restart_A got A=%h pc=%0d want 08/1",
               dut.regA_out_bus, dut.pc_out_bus);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    test_reset();
    test_load_add();
    test_logic();
    test_wrap_dual();
    test_pc_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
